// File: rtl/led_fade_driver.sv
// Board-side LED fader: each SoC LED bit ramps a PWM level toward full or dark.
// Shared prescaler paces the steps; shared PWM counter sets the duty cycle.
module led_fade_driver #(
    parameter int CLOCK_FREQ   = 25000000,
    parameter int FADE_STEP_HZ = 1000,
    parameter int NUM_LEDS     = 8,
    parameter int PWM_BITS     = 8,
    parameter int MAX_LEVEL    = 255,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_LEDS-1:0] leds_in,
    input  logic                enable,
    output logic [NUM_LEDS-1:0] led_out,
    output logic                fade_busy
);

    localparam int DIV     = CLOCK_FREQ / FADE_STEP_HZ;
    localparam int PS_BITS = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PS_BITS-1:0]  PS_LAST = PS_BITS'(DIV - 1);
    localparam logic [PWM_BITS-1:0] LVL_MAX = PWM_BITS'(MAX_LEVEL);
    localparam logic [NUM_LEDS-1:0] DARK    = {NUM_LEDS{ACTIVE_LOW}};

    logic [PS_BITS-1:0]                r_prescale;
    logic [PWM_BITS-1:0]               r_pwm_cnt;
    logic [NUM_LEDS-1:0]               r_tgt_q;
    logic [NUM_LEDS-1:0][PWM_BITS-1:0] r_level;
    logic [NUM_LEDS-1:0]               r_led_out;
    logic                              r_busy;

    logic                              w_tick;
    logic [NUM_LEDS-1:0]               w_on;
    logic [NUM_LEDS-1:0]               w_pending;
    logic [NUM_LEDS-1:0][PWM_BITS-1:0] w_next_level;
    logic [NUM_LEDS-1:0]               w_led_next;
    logic                              w_busy_next;

    assign w_tick = (r_prescale == PS_LAST);

    always_comb begin
        w_on         = '0;
        w_pending    = '0;
        w_next_level = r_level;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (r_level[i] == LVL_MAX) begin
                w_on[i] = 1'b1;
            end else if (r_level[i] == '0) begin
                w_on[i] = 1'b0;
            end else begin
                w_on[i] = (r_level[i] > r_pwm_cnt);
            end

            w_pending[i] = r_tgt_q[i] ? (r_level[i] != LVL_MAX)
                                      : (r_level[i] != '0);

            // Bypass parks the level at the settled extreme for a clean re-enable
            if (!enable) begin
                w_next_level[i] = r_tgt_q[i] ? LVL_MAX : '0;
            end else if (w_tick) begin
                if (r_tgt_q[i] && (r_level[i] < LVL_MAX)) begin
                    w_next_level[i] = r_level[i] + PWM_BITS'(1);
                end else if (!r_tgt_q[i] && (r_level[i] != '0)) begin
                    w_next_level[i] = r_level[i] - PWM_BITS'(1);
                end
            end
        end
    end

    assign w_led_next  = (enable ? w_on : r_tgt_q) ^ DARK;
    assign w_busy_next = enable && (|w_pending);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prescale <= '0;
            r_pwm_cnt  <= '0;
            r_tgt_q    <= '0;
            r_level    <= '0;
            r_led_out  <= DARK;
            r_busy     <= 1'b0;
        end else begin
            r_prescale <= w_tick ? '0 : r_prescale + PS_BITS'(1);
            r_pwm_cnt  <= r_pwm_cnt + PWM_BITS'(1);
            r_tgt_q    <= leds_in;
            r_level    <= w_next_level;
            r_led_out  <= w_led_next;
            r_busy     <= w_busy_next;
        end
    end

    assign led_out   = r_led_out;
    assign fade_busy = r_busy;

endmodule

// File: tb/tb_led_fade_driver.sv
// Directed bench for led_fade_driver with DIV=10, 4-bit PWM, 8 active-low LEDs.
// Edge numbers count rising edges since the last reset release.
module tb_led_fade_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] leds_in;
    logic       enable;
    logic [7:0] led_out;
    logic       fade_busy;

    int n_tests = 0;
    int n_fail  = 0;
    int ecount  = 0;

    led_fade_driver #(
        .CLOCK_FREQ  (1000),
        .FADE_STEP_HZ(100),
        .NUM_LEDS    (8),
        .PWM_BITS    (4),
        .MAX_LEVEL   (15),
        .ACTIVE_LOW  (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .leds_in  (leds_in),
        .enable   (enable),
        .led_out  (led_out),
        .fade_busy(fade_busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        ecount++;
    endtask

    task automatic run_to(input int e);
        while (ecount < e) step();
    endtask

    task automatic test_reset();
        rst = 1'b1; leds_in = 8'hFF; enable = 1'b0;
        #1;
        n_tests++;
        if (led_out !== 8'hFF || fade_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: led_out=%h busy=%b want FF/0", led_out, fade_busy);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            n_tests++;
            if (led_out !== 8'hFF || fade_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold%0d: led_out=%h busy=%b want FF/0", i, led_out, fade_busy);
            end
        end
        n_tests++;
        if (dut.r_level[0] !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_level: got %0d want 0", dut.r_level[0]);
        end
    endtask

    task automatic test_fade_up();
        rst = 1'b0; enable = 1'b1; leds_in = 8'h01; ecount = 0;
        step();
        n_tests++;
        if (fade_busy !== 1'b0) begin
            n_fail++; $display("FAIL busy_e1: got %b want 0", fade_busy);
        end
        step();
        n_tests++;
        if (fade_busy !== 1'b1) begin
            n_fail++; $display("FAIL busy_e2: got %b want 1", fade_busy);
        end
        run_to(9);
        n_tests++;
        if (dut.r_level[0] !== 4'd0) begin
            n_fail++; $display("FAIL up_e9: got %0d want 0", dut.r_level[0]);
        end
        run_to(10);
        n_tests++;
        if (dut.r_level[0] !== 4'd1) begin
            n_fail++; $display("FAIL up_e10: got %0d want 1", dut.r_level[0]);
        end
        run_to(149);
        n_tests++;
        if (dut.r_level[0] !== 4'd14) begin
            n_fail++; $display("FAIL up_e149: got %0d want 14", dut.r_level[0]);
        end
        run_to(150);
        n_tests++;
        if (dut.r_level[0] !== 4'd15 || fade_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL up_e150: level=%0d busy=%b want 15/1", dut.r_level[0], fade_busy);
        end
        run_to(151);
        n_tests++;
        if (fade_busy !== 1'b0) begin
            n_fail++; $display("FAIL up_busy_drop: got %b want 0", fade_busy);
        end
        for (int i = 0; i < 21; i++) begin
            n_tests++;
            if (led_out !== 8'hFE) begin
                n_fail++; $display("FAIL up_full e%0d: got %h want FE", ecount, led_out);
            end
            if (i < 20) step();
        end
    endtask

    task automatic test_duty();
        int   zeros;
        logic exp_bit;
        leds_in = 8'h00;
        run_to(240);
        n_tests++;
        if (dut.r_level[0] !== 4'd8) begin
            n_fail++; $display("FAIL duty_level: got %0d want 8", dut.r_level[0]);
        end
        zeros = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            exp_bit = (((ecount - 1) % 16) < 8) ? 1'b0 : 1'b1;
            n_tests++;
            if (led_out !== {7'h7F, exp_bit}) begin
                n_fail++;
                $display("FAIL duty e%0d: got %h want %h", ecount, led_out, {7'h7F, exp_bit});
            end
            if (led_out[0] == 1'b0) zeros++;
        end
        n_tests++;
        if (zeros != 8) begin
            n_fail++; $display("FAIL duty_count: got %0d want 8", zeros);
        end
    endtask

    task automatic test_reversal();
        int exp_lvl;
        run_to(320);
        n_tests++;
        if (dut.r_level[0] !== 4'd0) begin
            n_fail++; $display("FAIL down_e320: got %0d want 0", dut.r_level[0]);
        end
        run_to(330);
        n_tests++;
        if (dut.r_level[0] !== 4'd0) begin
            n_fail++; $display("FAIL down_sat: got %0d want 0", dut.r_level[0]);
        end
        run_to(335);
        leds_in = 8'h01;
        run_to(337);
        n_tests++;
        if (fade_busy !== 1'b1) begin
            n_fail++; $display("FAIL rev_busy_up: got %b want 1", fade_busy);
        end
        run_to(390);
        n_tests++;
        if (dut.r_level[0] !== 4'd6) begin
            n_fail++; $display("FAIL rev_at6: got %0d want 6", dut.r_level[0]);
        end
        run_to(391);
        leds_in = 8'h00;
        run_to(399);
        n_tests++;
        if (dut.r_level[0] !== 4'd6) begin
            n_fail++; $display("FAIL rev_hold6: got %0d want 6", dut.r_level[0]);
        end
        for (int k = 1; k <= 8; k++) begin
            run_to(390 + 10 * k);
            exp_lvl = (6 - k > 0) ? 6 - k : 0;
            n_tests++;
            if (dut.r_level[0] !== 4'(exp_lvl)) begin
                n_fail++;
                $display("FAIL rev_step%0d: got %0d want %0d", k, dut.r_level[0], exp_lvl);
            end
        end
        run_to(472);
        n_tests++;
        if (fade_busy !== 1'b0 || led_out !== 8'hFF) begin
            n_fail++;
            $display("FAIL rev_dark: led_out=%h busy=%b want FF/0", led_out, fade_busy);
        end
    endtask

    task automatic test_bypass();
        run_to(475);
        enable = 1'b0; leds_in = 8'hA5;
        step();
        n_tests++;
        if (led_out !== 8'hFF) begin
            n_fail++; $display("FAIL byp_lat1: got %h want FF", led_out);
        end
        step();
        n_tests++;
        if (led_out !== 8'h5A || fade_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL byp_lat2: led_out=%h busy=%b want 5A/0", led_out, fade_busy);
        end
        run_to(480);
        enable = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            n_tests++;
            if (led_out !== 8'h5A || fade_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL byp_reen e%0d: led_out=%h busy=%b want 5A/0", ecount, led_out, fade_busy);
            end
        end
        n_tests++;
        if (dut.r_level[0] !== 4'd15 || dut.r_level[1] !== 4'd0) begin
            n_fail++;
            $display("FAIL byp_levels: l0=%0d l1=%0d want 15/0", dut.r_level[0], dut.r_level[1]);
        end
    endtask

    task automatic test_reset_mid_fade();
        leds_in = 8'h00;
        run_to(570);
        n_tests++;
        if (dut.r_level[0] !== 4'd9) begin
            n_fail++; $display("FAIL mid_at9: got %0d want 9", dut.r_level[0]);
        end
        run_to(573);
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (led_out !== 8'hFF || fade_busy !== 1'b0 || dut.r_level[0] !== 4'd0) begin
            n_fail++;
            $display("FAIL mid_async: led_out=%h busy=%b l0=%0d want FF/0/0",
                     led_out, fade_busy, dut.r_level[0]);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (led_out !== 8'hFF) begin
                n_fail++; $display("FAIL mid_hold%0d: got %h want FF", i, led_out);
            end
        end
        leds_in = 8'h01; rst = 1'b0; ecount = 0;
        run_to(9);
        n_tests++;
        if (dut.r_level[0] !== 4'd0) begin
            n_fail++; $display("FAIL mid_e9: got %0d want 0", dut.r_level[0]);
        end
        run_to(10);
        n_tests++;
        if (dut.r_level[0] !== 4'd1) begin
            n_fail++; $display("FAIL mid_e10: got %0d want 1", dut.r_level[0]);
        end
        run_to(20);
        n_tests++;
        if (dut.r_level[0] !== 4'd2 || dut.r_level[2] !== 4'd0) begin
            n_fail++;
            $display("FAIL mid_e20: l0=%0d l2=%0d want 2/0", dut.r_level[0], dut.r_level[2]);
        end
    endtask

    initial begin
        test_reset();
        test_fade_up();
        test_duty();
        test_reversal();
        test_bypass();
        test_reset_mid_fade();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
